alu_serial_seq: RTL and testbench
=================================

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  slice control code, latched on accepted start.
REQ-006 cin  input  1  initial carry/invert bit, latched on accepted start.
REQ-007 a_in  input  WIDTH  operand A, latched on accepted start.
REQ-008 b_in  input  WIDTH  operand B, latched on accepted start.
REQ-009 busy  output  1  high in RUN and DONE states.
REQ-010 done  output  1  one-cycle pulse when result is valid.
REQ-011 result  output  WIDTH  completed result, held until next accepted start.
REQ-012 cout  output  1  final carry/pass-through bit, held with result.
REQ-013 zero  output  1  high when result == 0, held with result.

Function
REQ-014 The block shall compute one result bit per clock, LSB first, using the per-bit slice function below with a carry register c.
REQ-015 op=00: bit = a^b^c; next c = majority(a,b,c).
REQ-016 op=01: bit = a | (b^c); next c = c.
REQ-017 op=10: bit = a & (b^c); next c = c.
REQ-018 op=11: bit = c ? b : ~a; next c = c.
REQ-019 States shall be IDLE, RUN, DONE; reset state IDLE.
REQ-020 IDLE: start=1 shall latch a_in, b_in, op, cin (c<=cin), clear bit index to 0, go to RUN next cycle; start=0 stays IDLE.
REQ-021 RUN: each cycle shall process bit index i, write result bit i, update c, increment i; after bit WIDTH-1 go to DONE.
REQ-022 RUN shall last exactly WIDTH cycles; done asserts on the cycle after the last RUN cycle, i.e. WIDTH+1 cycles after the start-accept edge.
REQ-023 DONE: done=1 for exactly one cycle, cout=c, zero=(result==0), then return to IDLE.
REQ-024 Latency: start accepted at edge k -> done high during cycle k+WIDTH+1; next start accepted no earlier than edge k+WIDTH+2.
REQ-025 start asserted while busy shall be ignored; latched operands and op shall not change mid-operation.
REQ-026 Input changes on a_in/b_in/op/cin after acceptance shall not affect the running operation.
REQ-027 result, cout, zero shall be stable from DONE until the next accepted start; during RUN they may show partial values but zero/cout update only in DONE.
REQ-028 Addition overflow beyond WIDTH bits shall appear only on cout; result wraps modulo 2^WIDTH.
REQ-029 start held high continuously shall start a new operation each time IDLE is reached (back-to-back, one IDLE cycle between operations).

Reset
REQ-030 rst=1 at any edge, including mid-RUN, shall force IDLE, busy=0, done=0, result=0, cout=0, zero=1, bit index=0, c=0, discarding the operation.
REQ-031 rst shall take priority over start in the same cycle; start is not accepted during a reset cycle.

Verification
REQ-032 WIDTH=8, op=00, cin=0, A=0x5A, B=0x33 -> after 9 cycles done pulse, result=0x8D, cout=0, zero=0.
REQ-033 op=00, cin=1, A=0xFF, B=0x00 -> result=0x00, cout=1, zero=1.
REQ-034 op=01, cin=1, A=0x0F, B=0xF0 -> result=0x0F|0x0F=0x0F, cout=1; op=10, cin=0, same operands -> result=0x00, zero=1, cout=0.
REQ-035 op=11, cin=0, A=0x3C -> result=0xC3; cin=1, B=0x96 -> result=0x96, cout=1.
REQ-036 Start with A=0x01,B=0x01; pulse start again at cycle 3 and rst at cycle 5 -> second start ignored, outputs return to reset values at cycle 6, no done pulse; fresh start then completes normally with result=0x02.

Source files
------------

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: after an accepted start, one result bit per clock, LSB first, through a 4-op slice with a carry register.
// Results, cout and zero are held from DONE until the next accepted start.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             a_bit, b_bit, slice_bit, slice_c;

  // The slice is shared by every bit position; only the current index is active.
  always_comb begin
    a_bit = a_q[idx_q];
    b_bit = b_q[idx_q];
    slice_bit = 1'b0;
    slice_c   = c_q;
    case (op_q)
      2'b00: begin
        slice_bit = a_bit ^ b_bit ^ c_q;
        slice_c   = (a_bit & b_bit) | (a_bit & c_q) | (b_bit & c_q);
      end
      2'b01:   slice_bit = a_bit | (b_bit ^ c_q);
      2'b10:   slice_bit = a_bit & (b_bit ^ c_q);
      default: slice_bit = c_q ? b_bit : ~a_bit;
    endcase
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    c_d      = c_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          op_d     = op;
          c_d      = cin;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[idx_q] = slice_bit;
        c_d             = slice_c;
        idx_d           = idx_q + 1'b1;
        if (idx_q == IW'(WIDTH - 1)) begin
          // Flags are captured on the edge into DONE so they are valid with the done pulse.
          cout_d  = slice_c;
          zero_d  = (result_d == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      c_q      <= c_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: expected results are queued at start acceptance and
// compared when done pulses; covers latency, held outputs, ignored starts and mid-run reset.
module tb_alu_serial_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, start, cin;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in, b_in, result;
  logic             busy, done, cout, zero;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             zero;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .result(result), .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] m_op, input logic m_cin,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t             e;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mask;
    mask = {WIDTH{m_cin}};
    e.cout = m_cin;
    case (m_op)
      2'b00: begin
        sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, m_cin};
        e.res  = sum[WIDTH-1:0];
        e.cout = sum[WIDTH];
      end
      2'b01:   e.res = a | (b ^ mask);
      2'b10:   e.res = a & (b ^ mask);
      default: e.res = m_cin ? b : ~a;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 4 * WIDTH) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_cout"},   32'(cout),   32'(e.cout));
    check({tag, "_zero"},   32'(zero),   32'(e.zero));
  endtask

  // Launch one operation; optionally pulse start again while busy, which must be ignored.
  task automatic run_op(input logic [1:0] t_op, input logic t_cin,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit inject);
    int   k;
    bit   got;
    exp_t e;
    wait_idle();
    op = t_op; cin = t_cin; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    sb_q.push_back(model(t_op, t_cin, a, b));
    @(negedge clk);
    start = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
    op = 2'($urandom); cin = 1'($urandom);
    if (inject) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 3 * WIDTH && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    if (got && sb_q.size() > 0) begin
      // done is visible in the cycle after edge k+WIDTH.
      check("latency", 32'(cyc - k), 32'(WIDTH));
      check("busy_in_done", 32'(busy), 32'd1);
      e = sb_q.pop_front();
      check_out("op", e);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("result_held", 32'(result), 32'(e.res));
    end
  endtask

  initial begin
    int   n_done, c1, c2;
    exp_t e;

    rst = 1'b1; start = 1'b0; op = '0; cin = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    rst = 1'b0;

    run_op(2'b00, 1'b0, 8'h5A, 8'h33, 1'b0);
    run_op(2'b00, 1'b1, 8'hFF, 8'h00, 1'b1);
    run_op(2'b01, 1'b1, 8'h0F, 8'hF0, 1'b0);
    run_op(2'b10, 1'b0, 8'h0F, 8'hF0, 1'b1);
    run_op(2'b11, 1'b0, 8'h3C, 8'h00, 1'b0);
    run_op(2'b11, 1'b1, 8'h3C, 8'h96, 1'b0);
    run_op(2'b00, 1'b1, 8'h80, 8'h7F, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op(2'(i), 1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'(i & 1));

    // start held high: operations run back to back with one IDLE cycle between them.
    wait_idle();
    op = 2'b00; cin = 1'b0; a_in = 8'h12; b_in = 8'h34; start = 1'b1;
    sb_q.push_back(model(2'b00, 1'b0, 8'h12, 8'h34));
    sb_q.push_back(model(2'b00, 1'b0, 8'h12, 8'h34));
    n_done = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 4 * WIDTH && n_done < 2; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) c1 = cyc; else c2 = cyc;
        e = sb_q.pop_front();
        check_out("b2b", e);
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(n_done), 32'd2);
    check("b2b_gap", 32'(c2 - c1), 32'(WIDTH + 2));

    // Reset mid-run with start also high: operation discarded, start not accepted.
    wait_idle();
    op = 2'b00; cin = 1'b0; a_in = 8'h01; b_in = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_zero", 32'(zero), 32'd1);
    rst = 1'b0; start = 1'b0;
    n_done = 0;
    for (int i = 0; i < WIDTH + 3; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("no_done_after_rst", 32'(n_done), 32'd0);
    run_op(2'b00, 1'b0, 8'h01, 8'h01, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
